seq_div32_16: RTL and testbench
===============================

# seq_div32_16

Iterative restoring divider: 32-bit dividend ÷ 16-bit divisor → 16-bit quotient and 16-bit remainder, one quotient bit per clock. It is the inverse of the 16×16 array multiplier, so `Dividend = Quotient*Divisor + Remainder` round-trips any 32-bit product. It sits next to the multiplier in the arithmetic unit and is driven by a start/done handshake.

## Interface
- Parameters: none. Widths are fixed at 32/16 to pair with the 16-bit multiplier.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `Dividend`  in  32  captured on the accepting edge.
- `Divisor`  in  16  captured on the accepting edge.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; results and flags valid from this cycle.
- `Quotient`  out  16  held until the next `done`.
- `Remainder`  out  16  held until the next `done`.
- `div_zero`  out  1  Divisor was 0; valid and held with the results.
- `overflow`  out  1  quotient would not fit in 16 bits; valid and held with the results.

## Operation
- States: IDLE → CALC → DONE → IDLE.
- IDLE, or DONE with `start`=1: accept the request.
  - Latch the operands.
  - Load partial remainder `rem[16:0]` = {1'b0, Dividend[31:16]}.
  - Set the iteration count to 0.
- At acceptance, check for errors:
  - If Divisor==0: `div_zero`=1.
  - Else if Dividend[31:16] ≥ Divisor: `overflow`=1.
  - On either error, skip CALC and go directly to DONE.
  - Error result: `Quotient`=16'hFFFF, `Remainder`=16'h0000.
- CALC iteration i (0..15), consuming dividend bit 15−i MSB-first:
  - Shift: `rem` = {rem[15:0], dividend_bit}.
  - Trial: `trial` = rem − {1'b0, Divisor}. Form the low 16 bits as A + ~B + 1. The trial is non-negative iff rem[16] | carry_out.
  - If non-negative: `rem` = trial and the quotient bit = 1. Otherwise keep `rem` and the quotient bit = 0.
  - After i=15, go to DONE. `Quotient` = the collected bits; `Remainder` = rem[15:0].
- The no-overflow precondition guarantees rem < Divisor before every shift, so 17 bits suffice.
- DONE lasts exactly one cycle, then returns to IDLE unless `start` is accepted in that cycle.
- `start` while `busy`=1 is ignored and has no side effects.
- Reset values, including on reset mid-operation:
  - State = IDLE.
  - `busy`=0, `done`=0, `Quotient`=0, `Remainder`=0, `div_zero`=0, `overflow`=0.
  - No partial result is ever presented.

## Timing
- Accepting edge k: `busy` goes high after edge k.
- Normal operation:
  - 16 CALC edges, k+1 through k+16.
  - `done`=1 and `busy`=0 after edge k+16, so latency is 16 cycles.
  - Results and flags update on edge k+16.
- Error case: `done`=1 after edge k+1, so latency is 1 cycle.
- `done` is high for exactly one cycle.
- A `start` in the `done` cycle is accepted. `busy` rises on the next edge and `done` falls.
- Prior results persist until the next `done`.
- Outputs are registered; nothing is combinational from the inputs to the outputs.

## Structure
- Shared package `arith_pkg`:
  - State encoding `DIV_IDLE`/`DIV_CALC`/`DIV_DONE`.
  - `DIV_ITER`=16.
  - Error codes `DIV_ERR_Q`=16'hFFFF, `DIV_ERR_R`=16'h0000.
- Sub-module: the trial subtractor reuses the existing `CLA_16_bit` adder, with B=~Divisor and C_in=1, plus external bit-16 logic. No other sub-modules.

## Test plan
- Dividend=100, Divisor=7 → after 16 cycles, `done` pulses once with Q=14, R=2, both flags 0.
- Dividend=32'hFFFE0001, Divisor=16'hFFFF → Q=16'hFFFF, R=0.
  - Also sweep random A,B: feed the multiplier's A*B+R (R<B) → expect Q=A, Rem=R.
- Divisor=0, Dividend=32'h1234 → `done` one cycle after accept; `div_zero`=1, Q=16'hFFFF, R=0.
- Dividend=32'h00010000, Divisor=1 → `overflow`=1, Q=16'hFFFF, R=0, latency 1.
- Pulse `start` with new operands at cycle 5 of a 100/7 operation → ignored; result is still Q=14, R=2.
  - Drop `rst_n` at cycle 8 of a run → all outputs 0 and state IDLE, asynchronously.
  - Then 50/5 → Q=10, R=0.
- Back-to-back: assert `start` (1000/3) during the `done` cycle of 100/7 → second `done` 16 cycles later with Q=333, R=1. The first result is held until then.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider state encoding, iteration count, error codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arith_pkg;

  // Divider FSM encoding
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // One quotient bit is produced per CALC cycle
  localparam int unsigned DIV_ITER = 16;

  // Index of the final CALC iteration, sized to the iteration counter
  localparam logic [3:0] DIV_LAST_ITER = 4'(DIV_ITER - 1);

  // Result presented for divide-by-zero and quotient overflow
  localparam logic [15:0] DIV_ERR_Q = 16'hFFFF;
  localparam logic [15:0] DIV_ERR_R = 16'h0000;

endpackage

// File: rtl/CLA_16_bit.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a second lookahead level.
// Latency: purely combinational.
// Backpressure: none.
module CLA_16_bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] Sum,
  output logic        C_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic        cg1;
  logic        cg2;
  logic        cg3;
  logic        cg4;
  logic [3:0]  grp_cin;

  assign g = A & B;
  assign p = A ^ B;

  // Second-level lookahead: every group carry is a direct function of C_in,
  // so no carry ripples between groups.
  assign cg1 = grp_g[0] | (grp_p[0] & C_in);
  assign cg2 = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & C_in);
  assign cg3 = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & C_in);
  assign cg4 = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & C_in);

  assign grp_cin = {cg3, cg2, cg1, C_in};
  assign C_out   = cg4;

  for (genvar j = 0; j < 4; j++) begin : g_grp
    localparam int B0 = 4 * j;
    logic ci;

    assign ci = grp_cin[j];

    // Group generate / propagate for the upper lookahead level
    assign grp_g[j] = g[B0+3] | (p[B0+3] & g[B0+2]) | (p[B0+3] & p[B0+2] & g[B0+1])
                    | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
    assign grp_p[j] = p[B0+3] & p[B0+2] & p[B0+1] & p[B0];

    // In-group carries expanded from the group carry-in
    assign c[B0]   = ci;
    assign c[B0+1] = g[B0] | (p[B0] & ci);
    assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & ci);
    assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                   | (p[B0+2] & p[B0+1] & p[B0] & ci);
  end

  assign Sum = p ^ c;

endmodule

// File: rtl/seq_div32_16.sv
// Iterative restoring divider, 32-bit dividend / 16-bit divisor, one quotient bit per clock.
// Latency: 16 cycles from the accepting edge to done; 1 cycle for divide-by-zero/overflow.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
module seq_div32_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] Dividend,
  input  logic [15:0] Divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] Quotient,
  output logic [15:0] Remainder,
  output logic        div_zero,
  output logic        overflow
);

  import arith_pkg::*;

  div_state_t  state;
  div_state_t  state_nxt;

  // Partial remainder is always below the divisor between iterations, so only
  // its 16 low bits are stored; bit 16 exists only in the shifted value.
  logic [15:0] rem;
  logic [15:0] dvd_lo;     // unconsumed low dividend bits, MSB next
  logic [15:0] dvsr;
  logic [15:0] q_acc;
  logic [3:0]  iter_cnt;
  logic        pend_zero;
  logic        pend_ovf;

  logic        accept;
  logic        in_calc;
  logic        pend_err;
  logic        last_iter;
  logic        in_zero;
  logic        in_ovf;

  logic [16:0] rem_shift;
  logic [15:0] trial_lo;
  logic        trial_cout;
  logic        trial_ok;
  logic [15:0] rem_next;
  logic [15:0] q_next;

  // Request qualification and error classification of the incoming operands
  assign accept    = start && (state != DIV_CALC);
  assign in_calc   = (state == DIV_CALC);
  assign pend_err  = pend_zero | pend_ovf;
  assign last_iter = (iter_cnt == DIV_LAST_ITER);
  assign in_zero   = (Divisor == 16'h0000);
  assign in_ovf    = !in_zero && (Dividend[31:16] >= Divisor);

  // Trial subtraction rem_shift - divisor: low 16 bits as A + ~B + 1,
  // non-negative when the shifted-out bit or the carry is set.
  assign rem_shift = {rem, dvd_lo[15]};

  CLA_16_bit u_trial (
    .A     (rem_shift[15:0]),
    .B     (~dvsr),
    .C_in  (1'b1),
    .Sum   (trial_lo),
    .C_out (trial_cout)
  );

  assign trial_ok = rem_shift[16] | trial_cout;
  assign rem_next = trial_ok ? trial_lo : rem_shift[15:0];
  assign q_next   = {q_acc[14:0], trial_ok};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: errors spend a single CALC cycle, normal operands run 16
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (accept) state_nxt = DIV_CALC;
      DIV_CALC: if (pend_err || last_iter) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = accept ? DIV_CALC : DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      DIV_CALC: busy = 1'b1;
      DIV_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Working registers: load on acceptance, one shift/subtract step per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem       <= '0;
      dvd_lo    <= '0;
      dvsr      <= '0;
      q_acc     <= '0;
      iter_cnt  <= '0;
      pend_zero <= 1'b0;
      pend_ovf  <= 1'b0;
    end else if (accept) begin
      rem       <= Dividend[31:16];
      dvd_lo    <= Dividend[15:0];
      dvsr      <= Divisor;
      q_acc     <= '0;
      iter_cnt  <= '0;
      pend_zero <= in_zero;
      pend_ovf  <= in_ovf;
    end else if (in_calc && !pend_err) begin
      rem      <= rem_next;
      q_acc    <= q_next;
      dvd_lo   <= {dvd_lo[14:0], 1'b0};
      iter_cnt <= iter_cnt + 4'd1;
    end
  end

  // Visible results change only on the edge that enters DONE, so earlier
  // results stay put and no partial quotient is ever exposed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Quotient  <= '0;
      Remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else if (in_calc) begin
      if (pend_err) begin
        Quotient  <= DIV_ERR_Q;
        Remainder <= DIV_ERR_R;
        div_zero  <= pend_zero;
        overflow  <= pend_ovf;
      end else if (last_iter) begin
        Quotient  <= q_next;
        Remainder <= rem_next;
        div_zero  <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_div32_16.sv
// Self-checking bench for seq_div32_16: directed cases plus random sweeps against an arithmetic model.
// Latency: checks 16-cycle normal and 1-cycle error completion.
// Backpressure: exercises ignored start while busy and back-to-back start in the done cycle.
module tb_seq_div32_16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] Dividend;
  logic [15:0] Divisor;
  logic        busy;
  logic        done;
  logic [15:0] Quotient;
  logic [15:0] Remainder;
  logic        div_zero;
  logic        overflow;

  int n_assert = 0;
  int n_fail   = 0;

  seq_div32_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .busy      (busy),
    .done      (done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and step through its accepting edge
  task automatic start_op(input logic [31:0] dvd, input logic [15:0] dvs);
    start    = 1'b1;
    Dividend = dvd;
    Divisor  = dvs;
    tick();
    start    = 1'b0;
  endtask

  // Count cycles until done, bounded
  task automatic wait_done(output int lat);
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  // Arithmetic reference: plain division with the error rules
  task automatic model(input logic [31:0] dvd, input logic [15:0] dvs,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov, output int lat);
    longint unsigned qf;
    dz = 1'b0;
    ov = 1'b0;
    if (dvs == 16'd0) begin
      dz = 1'b1;
      q = 16'hFFFF; r = 16'h0000; lat = 1;
    end else begin
      qf = longint'(dvd) / longint'(dvs);
      if (qf > 64'd65535) begin
        ov = 1'b1;
        q = 16'hFFFF; r = 16'h0000; lat = 1;
      end else begin
        q = 16'(qf);
        r = 16'(longint'(dvd) % longint'(dvs));
        lat = 16;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                              input int lat_obs);
    logic [15:0] q, r;
    logic dz, ov;
    int lat;
    model(dvd, dvs, q, r, dz, ov, lat);
    check({tag, " latency"}, 32'(lat_obs), 32'(lat));
    check({tag, " Q"}, {16'd0, Quotient}, {16'd0, q});
    check({tag, " R"}, {16'd0, Remainder}, {16'd0, r});
    check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, dz});
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, ov});
    check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
  endtask

  // Full operation: start, wait, compare, confirm done is a single pulse
  task automatic run_op(input string tag, input logic [31:0] dvd, input logic [15:0] dvs);
    int lat;
    start_op(dvd, dvs);
    wait_done(lat);
    check_result(tag, dvd, dvs, lat);
    tick();
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] a, b, r, dvd;

    rst_n    = 1'b0;
    start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    #22;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset Q", {16'd0, Quotient}, 32'd0);
    check("reset R", {16'd0, Remainder}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic case, error cases, largest product
    run_op("100/7", 32'd100, 16'd7);
    run_op("ffff sq", 32'hFFFE0001, 16'hFFFF);
    run_op("divzero", 32'h1234, 16'd0);
    run_op("ovf", 32'h00010000, 16'd1);
    run_op("exact max", 32'hFFFEFFFF, 16'hFFFF);

    // start while busy is ignored
    start_op(32'd100, 16'd7);
    check("busy after accept", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    start    = 1'b1;
    Dividend = 32'd9999;
    Divisor  = 16'd3;
    tick();
    start    = 1'b0;
    wait_done(lat);
    check_result("ignore", 32'd100, 16'd7, (lat == 99) ? lat : lat + 5);

    // Asynchronous reset mid-operation
    tick();
    start_op(32'd100, 16'd7);
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst done", {31'd0, done}, 32'd0);
    check("arst Q", {16'd0, Quotient}, 32'd0);
    check("arst R", {16'd0, Remainder}, 32'd0);
    check("arst flags", {30'd0, div_zero, overflow}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post-arst idle", {30'd0, busy, done}, 32'd0);
    run_op("50/5", 32'd50, 16'd5);

    // Back-to-back: second start during the done cycle
    start_op(32'd100, 16'd7);
    wait_done(lat);
    check_result("b2b first", 32'd100, 16'd7, lat);
    start_op(32'd1000, 16'd3);
    check("b2b done fell", {31'd0, done}, 32'd0);
    check("b2b busy rose", {31'd0, busy}, 32'd1);
    check("b2b hold Q", {16'd0, Quotient}, 32'd14);
    check("b2b hold R", {16'd0, Remainder}, 32'd2);
    wait_done(lat);
    check_result("b2b second", 32'd1000, 16'd3, lat);
    tick();

    // Round trip of multiplier products plus remainder
    for (int i = 0; i < 24; i++) begin
      a   = 32'($urandom_range(0, 65535));
      b   = 32'($urandom_range(1, 65535));
      r   = 32'($urandom_range(0, int'(b) - 1));
      dvd = a * b + r;
      run_op("product", dvd, b[15:0]);
    end

    // Unconstrained operands: mix of overflow, zero divisor and normal cases
    for (int i = 0; i < 16; i++) begin
      dvd = $urandom;
      if (i % 2 == 0) dvd = dvd >> 12;
      b   = (i % 5 == 0) ? 32'd0 : 32'($urandom_range(0, 65535));
      run_op("random", dvd, b[15:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
